// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: shared state encoding, operation kinds and reset defaults for the stack sequencer
package stack_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, PUSH_CCR, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_CCR, VEC_HI, VEC_LO, DONE
  } state_t;
  typedef enum logic [1:0] {OP_CALL, OP_RET, OP_RTI, OP_IRQ} op_t;
  localparam logic [15:0] SP_RESET_DEF = 16'h07FF;
  localparam logic [15:0] VEC_ADDR_DEF = 16'h0000;
  function automatic logic is_push(input state_t s);
    return s inside {PUSH_CCR, PUSH_HI, PUSH_LO};
  endfunction
  function automatic logic is_pop(input state_t s);
    return s inside {POP_LO, POP_HI, POP_CCR};
  endfunction
endpackage

// File: rtl/stack_seq_sp_unit.sv
// stack_seq_sp_unit: stack pointer register, decrement on push, increment on pop, wraps mod 2^16
module stack_seq_sp_unit
  import stack_seq_pkg::*;
#(
  parameter logic [15:0] SP_RESET = SP_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  output logic [15:0] sp
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) sp <= SP_RESET;
    else if (push) sp <= sp - 16'd1;
    else if (pop) sp <= sp + 16'd1;
endmodule

// File: rtl/stack_seq.sv
// stack_seq: sequences CALL/RET/RTI/interrupt stack traffic on the data memory port
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter logic [15:0] SP_RESET = SP_RESET_DEF,
  parameter logic [15:0] VEC_ADDR = VEC_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        call,
  input  logic        ret,
  input  logic        rti,
  input  logic        interrupt,
  input  logic [31:0] ret_pc,
  input  logic [31:0] call_target,
  input  logic [2:0]  ccr_in,
  input  logic        mem_stall,
  input  logic [15:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        freeze,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        ccr_load,
  output logic [2:0]  ccr_out,
  output logic [15:0] sp
);
  state_t      state, nxt;
  op_t         op;
  logic        pend, push, pop, vec, req_any;
  logic [31:0] ret_l, tgt_l, pc_q, done_pc;
  logic [2:0]  ccr_l, ccr_q;
  logic [15:0] lo_q, hi_q;

  assign push    = !mem_stall && is_push(state);
  assign pop     = !mem_stall && is_pop(state);
  assign vec     = state inside {VEC_HI, VEC_LO};
  assign req_any = call || ret || rti;
  assign mem_req   = push || pop || (vec && !mem_stall);
  assign mem_we    = push;
  assign mem_addr  = is_push(state) ? sp : is_pop(state) ? sp + 16'd1 :
                     state == VEC_HI ? VEC_ADDR : state == VEC_LO ? VEC_ADDR + 16'd1 : '0;
  assign mem_wdata = state == PUSH_CCR ? {13'b0, ccr_l} : state == PUSH_HI ? ret_l[31:16] :
                     state == PUSH_LO ? ret_l[15:0] : '0;
  // the final word of a read sequence is still on mem_rdata while in DONE
  assign done_pc  = op == OP_CALL ? tgt_l : op == OP_RET ? {mem_rdata, lo_q} :
                    op == OP_RTI ? {hi_q, lo_q} : {hi_q, mem_rdata};
  assign freeze   = state != IDLE;
  assign pc_load  = state == DONE;
  assign ccr_load = pc_load && op == OP_RTI;
  assign pc_out   = pc_load ? done_pc : pc_q;
  assign ccr_out  = ccr_load ? mem_rdata[2:0] : ccr_q;

  always_comb
    nxt = state == PUSH_CCR ? PUSH_HI : state == PUSH_HI ? PUSH_LO :
          state == PUSH_LO ? (op == OP_IRQ ? VEC_HI : DONE) : state == POP_LO ? POP_HI :
          state == POP_HI ? (op == OP_RTI ? POP_CCR : DONE) : state == VEC_HI ? VEC_LO : DONE;

  stack_seq_sp_unit #(.SP_RESET(SP_RESET)) u_sp (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .sp(sp)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      op    <= OP_CALL;
      pend  <= 1'b0;
      ret_l <= '0;
      tgt_l <= '0;
      ccr_l <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      pc_q  <= '0;
      ccr_q <= '0;
    end else begin
      pend <= (state == IDLE && !req_any) ? 1'b0 : pend || interrupt;
      if (pc_load) begin
        pc_q <= done_pc;
        if (op == OP_RTI) ccr_q <= mem_rdata[2:0];
      end
      if (!mem_stall && state == POP_HI) lo_q <= mem_rdata;
      if (!mem_stall && (state == POP_CCR || state == VEC_LO)) hi_q <= mem_rdata;
      if (state == IDLE) begin
        if (req_any || interrupt || pend) begin
          ret_l <= ret_pc;
          tgt_l <= call_target;
          ccr_l <= ccr_in;
          op    <= call ? OP_CALL : ret ? OP_RET : rti ? OP_RTI : OP_IRQ;
          state <= call ? PUSH_HI : (ret || rti) ? POP_LO : PUSH_CCR;
        end
      end else if (state == DONE) state <= IDLE;
      else if (!mem_stall) state <= nxt;
    end
endmodule
